// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: widths, FSM encoding and the NOP word.
package fetch_stage_pkg;

  localparam int ADDR_W_DFLT = 64;
  localparam int INSTR_W     = 32;

  // LEGv8 NOP encoding; handy for benches that need a filler word.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503_201F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory channel: valid/ready request, valid-only response.
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT
);

  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  // Fetch side issues requests and consumes responses.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  // Memory side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/fetch_stage_hold_buf.sv
// One-entry skid buffer catching a fetched word while decode is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [INSTR_W-1:0] wr_instr,
  input  logic [ADDR_W-1:0]  wr_pc,
  input  logic               rd_en,
  input  logic               flush,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // Flush beats write beats read; the payload only moves on a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      instr <= wr_instr;
      pc    <= wr_pc;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch plus IF/ID register. One outstanding imem request,
// hazard stall via a one-entry hold buffer, branch redirect flushes everything.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DFLT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc
);

  fetch_state_e       state, state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               req_fire;
  logic               deliver;
  logic               hold_valid;
  logic               hold_wr;
  logic               hold_rd;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;

  // Request depends only on state, redirect and hold: never on the response.
  assign imem.imem_req_valid = (state == S_REQ) && !redirect_valid && !hold_valid;
  assign imem.imem_req_addr  = pc;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

  // A response is kept only if no redirect lands in the same cycle.
  assign deliver = (state == S_WAIT) && imem.imem_rsp_valid && !redirect_valid;

  // Park the word when decode holds a valid entry; drain it once decode moves.
  assign hold_wr = deliver && ifid_valid && stall;
  assign hold_rd = hold_valid && !(stall && ifid_valid);

  fetch_hold_buf #(.ADDR_W(ADDR_W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (hold_wr),
    .wr_instr (imem.imem_rsp_data),
    .wr_pc    (req_pc),
    .rd_en    (hold_rd),
    .flush    (redirect_valid),
    .valid    (hold_valid),
    .instr    (hold_instr),
    .pc       (hold_pc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a redirect during WAIT without a response leaves a stale
  // response in flight, so DRAIN swallows it before fetching again.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (req_fire) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rsp_valid)  state_nxt = S_REQ;
        else if (redirect_valid)  state_nxt = S_DRAIN;
      end
      S_DRAIN: if (imem.imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC and in-flight request address; a redirect overrides the +4 step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (req_fire) req_pc <= pc;
      if (redirect_valid && state != S_IDLE) pc <= redirect_pc;
      else if (req_fire)                     pc <= pc + ADDR_W'(4);
    end
  end

  // IF/ID register: flush > stall-hold > hold buffer > new response > bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (redirect_valid) begin
      ifid_valid <= 1'b0;
    end else if (stall && ifid_valid) begin
      ifid_valid <= 1'b1;
    end else if (hold_valid) begin
      ifid_valid <= 1'b1;
      ifid_instr <= hold_instr;
      ifid_pc    <= hold_pc;
    end else if (deliver) begin
      ifid_valid <= 1'b1;
      ifid_instr <= imem.imem_rsp_data;
      ifid_pc    <= req_pc;
    end else begin
      ifid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory model answers accepted requests
// after a random latency; a scoreboard holds the words decode should see.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;

  fetch_stage_if #(.ADDR_W(64)) imem ();

  fetch_stage #(.ADDR_W(64), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;

  // memory / program-order model
  bit          outst = 1'b0;
  bit          flushed = 1'b0;
  logic [63:0] out_addr = '0;
  int          wait_cnt = 0;
  logic [63:0] exp_pc = RST_PC;
  int          since_rst = 0;
  int          p_stall, p_redir, p_ready, max_lat;
  bit          hi_targets = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h8B02_0020;
  endfunction

  function automatic logic [63:0] pick_target();
    if (hi_targets) return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
    if ($urandom_range(0, 3) == 0) return 64'h100;
    return 64'($urandom_range(0, 1023)) << 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, update the model just before posedge.
  task automatic step();
    bit fire;
    @(negedge clk);
    if (rst_n) since_rst++;
    stall          = ($urandom_range(0, 99) < p_stall);
    redirect_valid = (since_rst > 2) && ($urandom_range(0, 99) < p_redir);
    redirect_pc    = pick_target();
    imem.imem_req_ready = ($urandom_range(0, 99) < p_ready);
    if (outst && wait_cnt == 0) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = mem_word(out_addr);
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = $urandom;
    end
    #4;
    fire = imem.imem_req_valid && imem.imem_req_ready;
    if (fire) begin
      chk("single_outstanding", 64'(outst), 64'd0);
      chk("req_addr", imem.imem_req_addr, exp_pc);
    end
    if (exp_q.size() == 2) chk("req_blocked_hold_full", 64'(imem.imem_req_valid), 64'd0);
    if (imem.imem_rsp_valid) begin
      outst = 1'b0;
      if (!redirect_valid && !flushed) exp_q.push_back('{imem.imem_rsp_data, out_addr});
    end else if (outst) begin
      if (redirect_valid) flushed = 1'b1;
      wait_cnt--;
    end
    if (fire) begin
      outst    = 1'b1;
      flushed  = 1'b0;
      out_addr = imem.imem_req_addr;
      wait_cnt = $urandom_range(1, max_lat) - 1;
    end
    if (redirect_valid)  exp_pc = redirect_pc;
    else if (fire)       exp_pc = exp_pc + 64'd4;
  endtask

  task automatic run_phase(input int ps, input int pr, input int prdy, input int lat, input int n);
    p_stall = ps; p_redir = pr; p_ready = prdy; max_lat = lat;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_valid"}, 64'(imem.imem_req_valid), 64'd0);
    chk({tag, "_ifid_valid"}, 64'(ifid_valid), 64'd0);
    chk({tag, "_ifid_instr"}, 64'(ifid_instr), 64'd0);
    chk({tag, "_ifid_pc"}, ifid_pc, 64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    outst = 1'b0; flushed = 1'b0; wait_cnt = 0;
    exp_pc = RST_PC; since_rst = 0;
    stall = 1'b0; redirect_valid = 1'b0;
    imem.imem_rsp_valid = 1'b0;
  endtask

  // Monitor: IF/ID must mirror the scoreboard head; decode consumes on !stall.
  initial forever begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      chk("ifid_valid", 64'(ifid_valid), 64'(exp_q.size() != 0));
      if (ifid_valid && exp_q.size() != 0) begin
        chk("ifid_instr", 64'(ifid_instr), 64'(exp_q[0].instr));
        chk("ifid_pc", ifid_pc, exp_q[0].pc);
      end
      if (redirect_valid)                            exp_q.delete();
      else if (ifid_valid && !stall && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    #2;
    chk_reset_outs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_phase(0, 0, 100, 1, 20);      // clean stream, 1-cycle memory
    run_phase(50, 0, 100, 3, 300);    // heavy stall, exercises hold buffer
    run_phase(10, 8, 70, 4, 300);     // redirects in every state
    hi_targets = 1'b1;
    run_phase(10, 10, 80, 3, 300);    // targets near the top: pc wrap
    hi_targets = 1'b0;

    // Reset while a request is in flight.
    p_redir = 0; p_stall = 0; p_ready = 100; max_lat = 4;
    for (int i = 0; i < 50 && !outst; i++) step();
    chk("reached_wait", 64'(outst), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outs("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_phase(0, 0, 100, 2, 10);
    run_phase(25, 5, 80, 4, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined LEGv8 core.
- Holds the PC and issues one outstanding request at a time to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents {valid, instr, pc} to the decode stage, where the immediate sign-extender consumes ifid_instr.
- Supports hazard-unit stall and branch-redirect flush.

Parameters:
- ADDR_W, 64, PC and memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_W  fetch address (current pc).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid; one response per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction word.
- stall  in  1  decode cannot accept; hold IF/ID.
- redirect_valid  in  1  taken branch (B, BL, CBZ, CBNZ resolved); flush and redirect.
- redirect_pc  in  ADDR_W  branch target.
- ifid_valid  out  1  IF/ID entry valid.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc  out  ADDR_W  address of ifid_instr.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, kill=0, hold_valid=0.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0.
  - imem_req_valid=0.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE -> REQ unconditionally on the first clock after reset release.
- imem_req_valid = (state==REQ) && !redirect_valid && !hold_valid. imem_req_addr = pc (valid whenever imem_req_valid=1).
- REQ:
  - On handshake (req_valid && req_ready): req_pc<=pc, pc<=pc+4 (modulo 2^ADDR_W, wrap-around at all-ones), go to WAIT.
  - With no handshake, stay in REQ.
- WAIT:
  - imem_rsp_valid && !redirect_valid: deliver {imem_rsp_data, req_pc}, go to REQ.
  - imem_rsp_valid && redirect_valid: discard the response, go to REQ.
  - !imem_rsp_valid && redirect_valid: go to DRAIN.
- DRAIN: wait for the stale response; on imem_rsp_valid discard it and go to REQ. A redirect while in DRAIN only updates pc.
- redirect_valid in any state after IDLE: pc<=redirect_pc, overriding any pc+4 update in the same cycle.
- Deliver path:
  - If (!ifid_valid || !stall): write the IF/ID register.
  - Else: write the one-entry hold buffer (hold_valid<=1, hold_instr, hold_pc).
  - No new request is issued while hold_valid=1, so the buffer never overflows.
- IF/ID update priority, highest first:
  1. redirect_valid: ifid_valid<=0, hold_valid<=0. Flush takes priority over stall.
  2. stall && ifid_valid: IF/ID unchanged.
  3. hold_valid: load from hold, hold_valid<=0.
  4. Delivered response: load it, ifid_valid<=1.
  5. Otherwise: ifid_valid<=0 (bubble). ifid_instr and ifid_pc keep their old values.
- Latency:
  - Request accepted at cycle N, response at cycle N+k: ifid_valid rises at the edge ending cycle N+k.
  - Back-to-back issue with 1-cycle memory gives 1 instruction every 2 cycles. Full throughput is out of scope.
- Stall while ifid_valid=0 has no effect; the next delivery loads IF/ID.
- Reset asserted mid-operation returns everything to reset values immediately.
  - After release, any in-flight memory response is not the block's concern; the memory is reset by the same rst_n.
- No combinational path from imem_rsp_* to imem_req_valid.

Decomposition:
- Shared core package holds:
  - ADDR_W default.
  - INSTR_W=32.
  - Fetch FSM state encoding (IDLE, REQ, WAIT, DRAIN).
  - NOP encoding constant for benches.
- One sub-module, fetch_hold_buf, for the one-entry hold buffer (write, read/clear, flush).

Test Plan:
- Reset release, req_ready=1, 1-cycle memory returning 0x8B020020 at address 0: ifid_valid=1, ifid_instr=0x8B020020, ifid_pc=0. Next request addr=4.
- Stall held 5 cycles with ifid_valid=1 and a response arriving during the stall: IF/ID unchanged, the response goes to hold, imem_req_valid=0. On stall release, IF/ID shows the held word and its pc, then requests resume at the next pc.
- redirect_valid with redirect_pc=0x100 while in WAIT, response arriving 3 cycles later: response discarded, ifid_valid=0, next request addr=0x100.
- Redirect and response in the same cycle: response dropped, IF/ID flushed, next addr=redirect_pc.
- Redirect during stall with hold_valid=1: ifid_valid=0, hold cleared, fetch resumes at the target.
- pc=0xFFFF_FFFF_FFFF_FFFC accepted: next imem_req_addr=0. rst_n pulled low in WAIT: all outputs 0 asynchronously, first request after release at RESET_PC.
